// File: rtl/mem_port_unit.sv
// Multicycle memory port: sequences one memory access per request, loads IR/MDR and updates the PC.
// Latency: request cycle + N BUSY cycles (through the ack, or 16 on timeout) + one DONE cycle.
// Backpressure: stall holds the controller from the request cycle until DONE; mem_ack is the only flow control.
module mem_port_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcWrite,
    input  logic        pcwWriteCond,
    input  logic        IorD,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        IRWrite,
    input  logic [1:0]  pcSource,
    input  logic        zero,
    input  logic [31:0] aluResult,
    input  logic [31:0] aluOut,
    input  logic [31:0] regB,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t      state;
    logic [3:0]  waitCnt;
    logic [31:0] rdBuf;
    logic        accRead;
    logic [31:0] pcNext;
    logic        pcEn;

    // Controller must freeze while a request is being launched or is in flight.
    assign stall = ((state == IDLE) && (memRead || memWrite)) || (state == BUSY);

    // PC source mux; the jump target uses the IR currently held, not one being loaded.
    always_comb begin
        pcNext = pc;
        case (pcSource)
            2'b00:   pcNext = aluResult;
            2'b01:   pcNext = aluOut;
            2'b10:   pcNext = {pc[31:28], ir[25:0], 2'b00};
            default: pcNext = pc;
        endcase
    end

    // PC may only move in IDLE or DONE; the illegal state performs no updates.
    assign pcEn = (pcWrite || (pcwWriteCond && zero)) && !stall
                  && ((state == IDLE) || (state == DONE));

    // Access sequencer plus the PC/IR/MDR architectural registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= 32'h0;
            ir        <= 32'h0;
            mdr       <= 32'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rdBuf     <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_err   <= 1'b0;
            waitCnt   <= 4'h0;
            accRead   <= 1'b0;
        end else begin
            if (pcEn) begin
                pc <= pcNext;
            end
            case (state)
                IDLE: begin
                    if (memRead || memWrite) begin
                        state     <= BUSY;
                        mem_addr  <= IorD ? aluOut : pc;
                        mem_we    <= memWrite;
                        mem_wdata <= regB;
                        mem_req   <= 1'b1;
                        waitCnt   <= 4'h0;
                        // A simultaneous write takes priority, so such an access never returns data.
                        accRead   <= memRead && !memWrite;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        if (accRead) begin
                            rdBuf <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end else if (waitCnt == 4'hF) begin
                        // Sixteenth silent cycle: give up, flag it, and hand back zero data.
                        mem_err <= 1'b1;
                        rdBuf   <= 32'h0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                DONE: begin
                    if (accRead) begin
                        mdr <= rdBuf;
                        if (IRWrite) begin
                            ir <= rdBuf;
                        end
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_unit.sv
// Self-checking bench for mem_port_unit: directed scenarios followed by random accesses.
// Expected PC/IR/MDR/error state comes from a transaction-level model kept here.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_mem_port_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcWrite, pcwWriteCond, IorD, memRead, memWrite, IRWrite;
    logic [1:0]  pcSource;
    logic        zero;
    logic [31:0] aluResult, aluOut, regB, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, pc, ir, mdr;
    logic        stall, mem_err;

    int checks = 0;
    int errors = 0;

    // Architectural reference state
    logic [31:0] expPc, expIr, expMdr;
    logic        expErr;

    always #5 clk = ~clk;

    mem_port_unit dut (
        .clk(clk), .rst_n(rst_n),
        .pcWrite(pcWrite), .pcwWriteCond(pcwWriteCond), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
        .pcSource(pcSource), .zero(zero),
        .aluResult(aluResult), .aluOut(aluOut), .regB(regB),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .ir(ir), .mdr(mdr),
        .stall(stall), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        pcWrite = 1'b0; pcwWriteCond = 1'b0; IorD = 1'b0;
        memRead = 1'b0; memWrite = 1'b0; IRWrite = 1'b0;
        pcSource = 2'b00; zero = 1'b0; mem_ack = 1'b0;
    endtask

    // Where the PC goes when it is allowed to move
    function automatic logic [31:0] modelTarget(input logic [1:0] src, input logic [31:0] curPc,
                                                input logic [31:0] curIr, input logic [31:0] ar,
                                                input logic [31:0] ao);
        if (src == 2'd0) return ar;
        if (src == 2'd1) return ao;
        if (src == 2'd2) return (curPc & 32'hF000_0000) | ((curIr & 32'h03FF_FFFF) << 2);
        return curPc;
    endfunction

    task automatic checkArch(input string tag);
        chk({tag, ".pc"},  {64'h0, pc},  {64'h0, expPc});
        chk({tag, ".ir"},  {64'h0, ir},  {64'h0, expIr});
        chk({tag, ".mdr"}, {64'h0, mdr}, {64'h0, expMdr});
        chk({tag, ".err"}, {95'h0, mem_err}, {95'h0, expErr});
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, ".bus"}, {30'h0, mem_req, mem_we, mem_addr, mem_wdata}, 96'h0);
        chk({tag, ".stall"}, {95'h0, stall}, 96'h0);
        checkArch(tag);
    endtask

    task automatic applyReset();
        clearInputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        expPc = 32'h0; expIr = 32'h0; expMdr = 32'h0; expErr = 1'b0;
    endtask

    // One controller-held memory access. ackAt is the BUSY cycle (1-based) that sees mem_ack;
    // anything outside 1..16 means the memory never answers.
    task automatic doAccess(input logic rd, input logic wr, input logic irw, input logic pcw,
                            input logic cond, input logic zr, input logic iord,
                            input logic [1:0] src, input logic [31:0] ar, input logic [31:0] ao,
                            input logic [31:0] rb, input logic [31:0] data, input int ackAt,
                            input string tag);
        logic [31:0] expAddr, buffer, target;
        logic        answered;
        int          busy, expBusy;
        answered = (ackAt >= 1) && (ackAt <= 16);
        expBusy  = answered ? ackAt : 16;
        buffer   = answered ? data : 32'h0;
        expAddr  = iord ? ao : expPc;
        memRead = rd; memWrite = wr; IRWrite = irw; pcWrite = pcw;
        pcwWriteCond = cond; zero = zr; IorD = iord; pcSource = src;
        aluResult = ar; aluOut = ao; regB = rb; mem_ack = 1'b0;
        #1;
        chk({tag, ".reqStall"}, {95'h0, stall}, {95'h0, 1'b1});
        busy = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (!stall) break;
            busy++;
            chk({tag, ".busyBus"}, {30'h0, mem_req, mem_we, mem_addr, mem_wdata},
                {30'h0, 1'b1, wr, expAddr, rb});
            mem_ack   = (busy == ackAt);
            mem_rdata = (busy == ackAt) ? data : $urandom;
        end
        mem_ack = 1'b0;
        chk({tag, ".busyCycles"}, 96'(busy), 96'(expBusy));
        if (!answered) expErr = 1'b1;
        chk({tag, ".doneBus"}, {93'h0, mem_req, mem_we, mem_err}, {93'h0, 1'b0, 1'b0, expErr});
        // DONE-cycle architectural effects, computed from the state before this edge
        target = modelTarget(src, expPc, expIr, ar, ao);
        if (pcw || (cond && zr)) expPc = target;
        if (rd && !wr) begin
            expMdr = buffer;
            if (irw) expIr = buffer;
        end
        tick();
        clearInputs();
        #1;
        checkArch(tag);
    endtask

    // A cycle with no memory strobe: only the PC may move.
    task automatic pcOp(input logic pcw, input logic cond, input logic zr, input logic [1:0] src,
                        input logic [31:0] ar, input logic [31:0] ao, input string tag);
        pcWrite = pcw; pcwWriteCond = cond; zero = zr; pcSource = src;
        aluResult = ar; aluOut = ao;
        #1;
        chk({tag, ".stall"}, {95'h0, stall}, 96'h0);
        if (pcw || (cond && zr)) expPc = modelTarget(src, expPc, expIr, ar, ao);
        tick();
        clearInputs();
        #1;
        checkArch(tag);
    endtask

    initial begin
        clearInputs();
        aluResult = 32'h0; aluOut = 32'h0; regB = 32'h0; mem_rdata = 32'h0;

        // Reset values
        applyReset();
        checkResetOutputs("reset");

        // Fetch: two BUSY cycles, PC steps to 4 together with the IR load
        doAccess(1, 0, 1, 1, 0, 0, 0, 2'b00, 32'h4, 32'h0, 32'h0, 32'h8C22_0004, 2, "fetch");

        // Load via ALUOut, IR and PC untouched
        doAccess(1, 0, 0, 0, 0, 0, 1, 2'b00, 32'h0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, "load");

        // Store, MDR untouched
        doAccess(0, 1, 0, 0, 0, 0, 1, 2'b00, 32'h0, 32'h40, 32'h1234_5678, 32'hFFFF_FFFF, 3, "store");

        // Read and write together: write wins, nothing captured
        doAccess(1, 1, 1, 0, 0, 0, 1, 2'b00, 32'h0, 32'h80, 32'hCAFE_F00D, 32'h5555_AAAA, 2, "rdwr");

        // Conditional branch: not taken, then taken
        pcOp(0, 1, 0, 2'b01, 32'h0, 32'h20, "brNotTaken");
        pcOp(0, 1, 1, 2'b01, 32'h0, 32'h20, "brTaken");

        // Load a jump word into IR, then jump to {pc[31:28], 26'h10, 2'b00}
        doAccess(1, 0, 1, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0800_0010, 1, "jFetch");
        pcOp(1, 0, 0, 2'b10, 32'h0, 32'h0, "jump");
        chk("jumpTarget", {64'h0, pc}, {64'h0, 32'h0000_0040});

        // Memory never answers: timeout after 16 BUSY cycles, zero data, sticky error
        doAccess(1, 0, 0, 0, 0, 0, 1, 2'b00, 32'h0, 32'h200, 32'h0, 32'h1111_2222, 0, "timeout");
        doAccess(1, 0, 1, 1, 0, 0, 0, 2'b00, expPc + 32'd4, 32'h0, 32'h0, 32'h2002_0003, 1, "afterTo");

        // Ack arriving exactly on the last allowed cycle is still a success
        doAccess(1, 0, 0, 0, 0, 0, 1, 2'b00, 32'h0, 32'h300, 32'h0, 32'h7777_8888, 16, "lastAck");

        // Reset during the second BUSY cycle, ack arrives one cycle later
        applyReset();
        memRead = 1'b1; IRWrite = 1'b1; pcWrite = 1'b1; aluResult = 32'h4;
        tick();              // first BUSY cycle
        tick();              // second BUSY cycle
        rst_n = 1'b0;
        tick();              // reset edge
        rst_n = 1'b1;
        clearInputs();
        mem_ack = 1'b1; mem_rdata = 32'hBADC_0FFE;
        #1;
        chk("midRst.req", {95'h0, mem_req}, 96'h0);
        tick();
        mem_ack = 1'b0;
        tick();
        checkResetOutputs("midRst");

        // Random accesses against the model
        for (int n = 0; n < 40; n++) begin
            int          op, ackAt;
            logic [31:0] a1, a2, b, d;
            op    = $urandom_range(0, 3);
            ackAt = $urandom_range(1, 18);
            a1 = $urandom; a2 = $urandom; b = $urandom; d = $urandom;
            case (op)
                0: doAccess(1, 0, 1, 1'($urandom), 0, 0, 0, 2'($urandom), a1, a2, b, d, ackAt, "rndFetch");
                1: doAccess(1, 0, 1'($urandom), 0, 1'($urandom), 1'($urandom), 1, 2'($urandom),
                            a1, a2, b, d, ackAt, "rndLoad");
                2: doAccess(1'($urandom), 1, 1'($urandom), 0, 0, 0, 1'($urandom), 2'b00,
                            a1, a2, b, d, ackAt, "rndStore");
                default: pcOp(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), a1, a2, "rndPc");
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
